// File: rtl/rgmii_speed_ctrl_if.sv
// MDIO pin bundle between the speed controller (master) and the PHY pad/model (slave).
// mdio_t = 1 releases the line so the PHY can drive mdio_i.
interface rgmii_speed_ctrl_if;
  logic mdc;
  logic mdio_i;
  logic mdio_o;
  logic mdio_t;

  modport master (output mdc, output mdio_o, output mdio_t, input mdio_i);
  modport slave  (input mdc, input mdio_o, input mdio_t, output mdio_i);
endinterface

// File: rtl/rgmii_speed_ctrl.sv
// Polls a clause-22 PHY status register over MDIO and drives the RGMII speed select,
// link flag and an interface reset pulse that re-initialises the RGMII block on speed change.
module rgmii_speed_ctrl #(
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter logic [4:0] STATUS_REG    = 5'h11,
  parameter int         SPEED_MSB     = 15,
  parameter int         RESOLVED_BIT  = 11,
  parameter int         LINK_BIT      = 10,
  parameter int         CLK_DIV       = 25,
  parameter int         POLL_INTERVAL = 1250000,
  parameter int         RST_CYCLES    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       poll_now,
  rgmii_speed_ctrl_if.master         mdio,
  output logic [1:0]                 speed,
  output logic                       link_up,
  output logic                       phy_if_rst,
  output logic                       busy,
  output logic [15:0]                status_data
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, EVAL} state_t;

  localparam int            TW         = $clog2(POLL_INTERVAL + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(POLL_INTERVAL - 1);
  localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0]    RST_LEN    = 8'(RST_CYCLES);
  // Preamble, ST=01, OP=10 (read), PHY address, register address; TA/DATA are released.
  localparam logic [45:0]   TX_FRAME   = {32'hFFFF_FFFF, 4'b0110, PHY_ADDR, STATUS_REG};

  state_t        state;
  logic [7:0]    div_cnt;
  logic [5:0]    bit_cnt;
  logic [45:0]   tx_sr;
  logic [15:0]   rx_sr;
  logic [TW-1:0] poll_timer;
  logic          pending;
  logic          first_done;
  logic [7:0]    rst_cnt;

  logic          tick;
  logic          mdc_rise;
  logic          mdc_fall;
  logic          start_frame;
  logic [1:0]    new_speed;
  logic          new_link;
  logic          speed_change;

  assign tick        = (div_cnt == DIV_LAST);
  assign mdc_rise    = tick & ~mdio.mdc;
  assign mdc_fall    = tick & mdio.mdc;
  assign start_frame = ((state == IDLE) && ((poll_timer == TIMER_LAST) || pending || poll_now)) ||
                       ((state == EVAL) && pending);

  assign new_speed    = rx_sr[SPEED_MSB -: 2];
  assign new_link     = rx_sr[LINK_BIT] & rx_sr[RESOLVED_BIT];
  assign speed_change = new_link && (new_speed != 2'b11) && (new_speed != speed);

  // Frame FSM: MDC divider, bit sequencing and the poll timer / request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      mdio.mdc    <= 1'b0;
      mdio.mdio_o <= 1'b1;
      mdio.mdio_t <= 1'b1;
      tx_sr       <= '1;
      rx_sr       <= '0;
      poll_timer  <= TIMER_LAST;
      pending     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (start_frame)
        pending <= 1'b0;
      else if (poll_now)
        pending <= 1'b1;

      if (start_frame) begin
        state       <= PRE;
        busy        <= 1'b1;
        poll_timer  <= '0;
        div_cnt     <= '0;
        bit_cnt     <= '0;
        mdio.mdc    <= 1'b0;
        mdio.mdio_o <= TX_FRAME[45];
        mdio.mdio_t <= 1'b0;
        tx_sr       <= {TX_FRAME[44:0], 1'b1};
      end else begin
        case (state)
          IDLE: poll_timer <= poll_timer + 1'b1;
          EVAL: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            if (tick) begin
              div_cnt  <= '0;
              mdio.mdc <= ~mdio.mdc;
            end else begin
              div_cnt  <= div_cnt + 1'b1;
            end
            if (mdc_rise && (state == DATA))
              rx_sr <= {rx_sr[14:0], mdio.mdio_i};
            // Next bit goes out on the falling edge; bit_cnt names the bit just finished.
            if (mdc_fall) begin
              bit_cnt     <= bit_cnt + 1'b1;
              mdio.mdio_o <= tx_sr[45];
              tx_sr       <= {tx_sr[44:0], 1'b1};
              case (bit_cnt)
                6'd31: state <= HDR;
                6'd45: begin
                  state       <= TA;
                  mdio.mdio_t <= 1'b1;
                end
                6'd47: state <= DATA;
                6'd63: begin
                  state       <= EVAL;
                  mdio.mdio_o <= 1'b1;
                  mdio.mdio_t <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  // Speed/link update and interface reset pulse; the first evaluation always releases reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed       <= 2'b10;
      link_up     <= 1'b0;
      status_data <= '0;
      phy_if_rst  <= 1'b1;
      rst_cnt     <= '0;
      first_done  <= 1'b0;
    end else begin
      if (rst_cnt != 8'd0) begin
        rst_cnt <= rst_cnt - 1'b1;
        if (rst_cnt == 8'd1)
          phy_if_rst <= 1'b0;
      end
      if (state == EVAL) begin
        status_data <= rx_sr;
        link_up     <= new_link;
        first_done  <= 1'b1;
        if (speed_change)
          speed <= new_speed;
        if (speed_change || !first_done) begin
          phy_if_rst <= 1'b1;
          rst_cnt    <= RST_LEN;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgmii_speed_ctrl.sv
// Bench for rgmii_speed_ctrl: PHY model on MDIO plus a rule-level model of link/speed/reset behaviour.
// Timing is checked through cycle stamps of observable edges (mdio_t, busy, phy_if_rst).
module tb_rgmii_speed_ctrl;

  localparam int         CLK_DIV       = 2;
  localparam int         POLL_INTERVAL = 1000;
  localparam int         RST_CYCLES    = 16;
  localparam logic [4:0] PHY_ADDR      = 5'h01;
  localparam logic [4:0] STATUS_REG    = 5'h11;
  localparam int         FRAME_CYCLES  = 128 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        poll_now = 1'b0;
  logic [1:0]  speed;
  logic        link_up;
  logic        phy_if_rst;
  logic        busy;
  logic [15:0] status_data;

  rgmii_speed_ctrl_if mdio ();

  rgmii_speed_ctrl #(
    .PHY_ADDR      (PHY_ADDR),
    .STATUS_REG    (STATUS_REG),
    .SPEED_MSB     (15),
    .RESOLVED_BIT  (11),
    .LINK_BIT      (10),
    .CLK_DIV       (CLK_DIV),
    .POLL_INTERVAL (POLL_INTERVAL),
    .RST_CYCLES    (RST_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .poll_now    (poll_now),
    .mdio        (mdio),
    .speed       (speed),
    .link_up     (link_up),
    .phy_if_rst  (phy_if_rst),
    .busy        (busy),
    .status_data (status_data)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // PHY model: rise_cnt is the index of the bit the master samples on the next MDC rise.
  int          rise_cnt = 0;
  int          n_frames = 0;
  int          last_frame_start = 0;
  int          t_fall_cyc = 0;
  logic [15:0] phy_reply = 16'h0000;
  logic [63:0] cap_o;
  logic [63:0] cap_t;

  assign mdio.mdio_i = (rise_cnt >= 48) ? phy_reply[15 - (rise_cnt % 16)] : 1'b1;

  always @(posedge mdio.mdc or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt <= 0;
    end else begin
      cap_o[63 - rise_cnt] <= mdio.mdio_o;
      cap_t[63 - rise_cnt] <= mdio.mdio_t;
      if (rise_cnt == 63) begin
        n_frames         <= n_frames + 1;
        last_frame_start <= t_fall_cyc;
      end
      rise_cnt <= (rise_cnt + 1) % 64;
    end
  end

  // Edge stamps, sampled mid-cycle.
  int   busy_fall_cyc = 0, rst_rise_cyc = 0, rst_fall_cyc = 0;
  int   mdc_rise_cyc = 0, mdc_period = 0;
  logic prev_t = 1'b1, prev_busy = 1'b0, prev_rst = 1'b1, prev_mdc = 1'b0;

  always @(negedge clk) begin
    if (prev_t && !mdio.mdio_t) t_fall_cyc = cyc;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    if (!prev_rst && phy_if_rst) rst_rise_cyc = cyc;
    if (prev_rst && !phy_if_rst) rst_fall_cyc = cyc;
    if (!prev_mdc && mdio.mdc) begin
      mdc_period   = cyc - mdc_rise_cyc;
      mdc_rise_cyc = cyc;
    end
    prev_t    = mdio.mdio_t;
    prev_busy = busy;
    prev_rst  = phy_if_rst;
    prev_mdc  = mdio.mdc;
  end

  // Reference model state.
  logic [1:0] m_speed = 2'b10;
  logic       m_first = 1'b1;
  int         last_e = 0;
  int         frames_expected = 0;

  localparam logic [45:0] EXP_O = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, STATUS_REG};
  localparam logic [63:0] EXP_T = {46'd0, 18'h3FFFF};

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic waitRise(input int n);
    int budget;
    budget = 4 * (POLL_INTERVAL + FRAME_CYCLES);
    while (rise_cnt < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("wait_bit", 64'(rise_cnt >= n), 64'(1));
  endtask

  task automatic waitFrames(input int target);
    int budget;
    budget = 4 * (POLL_INTERVAL + FRAME_CYCLES);
    while (n_frames < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("frame_done", 64'(n_frames >= target), 64'(1));
    repeat (CLK_DIV + 2) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] reply, input int poll_pulses);
    phy_reply = reply;
    frames_expected++;
    for (int k = 0; k < poll_pulses; k++) begin
      waitRise(50 + 6 * k);
      poll_now = 1'b1;
      @(negedge clk);
      poll_now = 1'b0;
    end
    waitFrames(frames_expected);
  endtask

  task automatic checkPoll(input logic [15:0] reply, input int exp_gap, input bit expect_idle);
    int         e;
    logic       exp_link, chg, exp_pulse, was_first;
    logic [1:0] sp;
    e = last_frame_start + FRAME_CYCLES;
    if (exp_gap >= 0)
      checkOutput("poll_gap", 64'(last_frame_start - last_e), 64'(exp_gap));
    last_e    = e;
    exp_link  = reply[10] & reply[11];
    sp        = reply[15:14];
    chg       = exp_link && (sp != 2'b11) && (sp != m_speed);
    was_first = m_first;
    exp_pulse = chg || m_first;
    if (chg) m_speed = sp;
    m_first = 1'b0;
    checkOutput("status_data", 64'(status_data), 64'(reply));
    checkOutput("link_up", 64'(link_up), 64'(exp_link));
    checkOutput("speed", 64'(speed), 64'(m_speed));
    if (expect_idle)
      checkOutput("eval_to_idle", 64'(busy_fall_cyc), 64'(e + 1));
    else
      checkOutput("back_to_back_start", 64'(t_fall_cyc), 64'(e + 1));
    repeat (RST_CYCLES + 4) @(negedge clk);
    if (exp_pulse) begin
      checkOutput("pulse_end", 64'(rst_fall_cyc), 64'(e + RST_CYCLES + 1));
      if (!was_first)
        checkOutput("pulse_start", 64'(rst_rise_cyc), 64'(e + 1));
    end else begin
      checkOutput("no_pulse", 64'({phy_if_rst, (rst_fall_cyc > e)}), 64'(0));
    end
  endtask

  function automatic logic [15:0] randReply();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 3) != 0) v[11:10] = 2'b11;
    return v;
  endfunction

  initial begin
    int          rel_cyc;
    logic [15:0] r;

    repeat (3) @(negedge clk);
    checkOutput("reset_state",
                64'({mdio.mdc, mdio.mdio_o, mdio.mdio_t, speed, link_up, phy_if_rst, busy, status_data}),
                64'({1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0000}));
    rel_cyc = cyc;
    rst_n   = 1'b1;

    applyStimulus(16'hAC00, 0);
    checkOutput("first_frame_start", 64'(last_frame_start), 64'(rel_cyc + 1));
    checkOutput("frame_mdio_o", 64'(cap_o[63:18]), 64'(EXP_O));
    checkOutput("frame_mdio_t", cap_t, EXP_T);
    checkOutput("mdc_period", 64'(mdc_period), 64'(2 * CLK_DIV));
    checkPoll(16'hAC00, -1, 1'b1);

    applyStimulus(16'h6C00, 0);
    checkPoll(16'h6C00, POLL_INTERVAL + 1, 1'b1);
    applyStimulus(16'h0000, 0);
    checkPoll(16'h0000, POLL_INTERVAL + 1, 1'b1);
    applyStimulus(16'hEC00, 0);
    checkPoll(16'hEC00, POLL_INTERVAL + 1, 1'b1);

    // Two requests during DATA collapse into one immediate extra frame.
    r = randReply();
    applyStimulus(r, 2);
    checkPoll(r, POLL_INTERVAL + 1, 1'b0);
    r = randReply();
    applyStimulus(r, 0);
    checkPoll(r, 1, 1'b1);
    r = randReply();
    applyStimulus(r, 0);
    checkPoll(r, POLL_INTERVAL + 1, 1'b1);

    for (int i = 0; i < 4; i++) begin
      r = randReply();
      applyStimulus(r, 0);
      checkPoll(r, POLL_INTERVAL + 1, 1'b1);
    end

    // Asynchronous reset in the middle of DATA, then a fresh frame from the preamble.
    phy_reply = randReply();
    waitRise(52);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset",
                64'({mdio.mdc, mdio.mdio_o, mdio.mdio_t, speed, link_up, phy_if_rst, busy, status_data}),
                64'({1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 16'h0000}));
    m_speed = 2'b10;
    m_first = 1'b1;
    repeat (2) @(negedge clk);
    rel_cyc = cyc;
    rst_n   = 1'b1;
    r = randReply();
    applyStimulus(r, 0);
    checkOutput("restart_frame_start", 64'(last_frame_start), 64'(rel_cyc + 1));
    checkOutput("restart_mdio_o", 64'(cap_o[63:18]), 64'(EXP_O));
    checkOutput("restart_mdio_t", cap_t, EXP_T);
    checkPoll(r, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
